// File: rtl/uart_rx_debug.sv
// rtl/uart_rx_debug.sv - 8N1 UART receiver, 16x oversampled, with ack handshake and error flags
module uart_rx_debug #(
    parameter int BAUD_DIV = 456,
    parameter int OVS      = 16
) (
    input  logic       clock,
    input  logic       resetGral,
    input  logic       uartRxPin,
    input  logic       rdAck,
    output logic [7:0] rxData,
    output logic       dataAvailable,
    output logic       framingError,
    output logic       overrun,
    output logic       busy
);

    localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TC_LAST  = TW'(OVS - 1);
    localparam logic [TW-1:0] TC_MID   = TW'(OVS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAITHI
    } state_t;

    state_t state;
    state_t state_next;

    logic          rx_meta;
    logic          rx_s;
    logic [DW-1:0] div_cnt;
    logic [TW-1:0] tc;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          tick;
    logic          start_mid;
    logic          bit_mid;
    logic          complete;
    logic          stop_bad;

    // Divider only runs inside a frame, so each frame starts phase-aligned to its start edge
    assign tick      = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign start_mid = (state == S_START) && tick && (tc == TC_MID);
    assign bit_mid   = tick && (tc == TC_LAST);
    assign complete  = (state == S_STOP) && bit_mid && rx_s;
    assign stop_bad  = (state == S_STOP) && bit_mid && !rx_s;

    always_ff @(posedge clock) begin
        if (resetGral) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uartRxPin;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (resetGral) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (start_mid) begin
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_mid && (bit_cnt == 3'd7)) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_mid) begin
                    state_next = rx_s ? S_IDLE : S_WAITHI;
                end
            end
            S_WAITHI: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (resetGral) begin
            div_cnt <= '0;
            tc      <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (state == S_IDLE) begin
            div_cnt <= '0;
            tc      <= '0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                // tc wraps at mid-start so data bits are sampled OVS ticks apart from there
                tc <= (start_mid || tc == TC_LAST) ? '0 : tc + 1'b1;
            end
            if ((state == S_DATA) && bit_mid) begin
                shift   <= {rx_s, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resetGral) begin
            rxData        <= 8'h00;
            dataAvailable <= 1'b0;
            framingError  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framingError <= stop_bad;
            if (complete) begin
                rxData        <= shift;
                dataAvailable <= 1'b1;
                // An ack in the completion cycle consumes the old byte, so no overrun
                if (rdAck) begin
                    overrun <= 1'b0;
                end else if (dataAvailable) begin
                    overrun <= 1'b1;
                end
            end else if (rdAck && dataAvailable) begin
                dataAvailable <= 1'b0;
                overrun       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_debug.sv
// tb/tb_uart_rx_debug.sv - randomized frame bench for uart_rx_debug against a timing-arithmetic model
module tb_uart_rx_debug;

    localparam int D   = 4;
    localparam int BIT = 16 * D;

    logic       clock;
    logic       resetGral;
    logic       uartRxPin;
    logic       rdAck;
    logic [7:0] rxData;
    logic       dataAvailable;
    logic       framingError;
    logic       overrun;
    logic       busy;

    uart_rx_debug #(.BAUD_DIV(D), .OVS(16)) dut (
        .clock         (clock),
        .resetGral     (resetGral),
        .uartRxPin     (uartRxPin),
        .rdAck         (rdAck),
        .rxData        (rxData),
        .dataAvailable (dataAvailable),
        .framingError  (framingError),
        .overrun       (overrun),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = -1;
    int fe_count = 0;
    bit prev_da = 1'b0;

    // Model: line seen two edges late; a frame is judged by edge offsets from its start detection
    int         phase = 0;
    int         rel = 0;
    bit         h1 = 1'b1;
    bit         h2 = 1'b1;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_data = 8'h00;
    bit         m_da = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_fe = 1'b0;

    task automatic model_step();
        bit rx;
        bit comp;
        int k;
        if (resetGral) begin
            h1 = 1'b1; h2 = 1'b1; phase = 0;
            m_da = 1'b0; m_data = 8'h00; m_ovr = 1'b0; m_fe = 1'b0;
        end else begin
            rx = h2; h2 = h1; h1 = uartRxPin;
            m_fe = 1'b0; comp = 1'b0;
            case (phase)
                0: if (!rx) begin phase = 1; rel = 0; m_byte = 8'h00; end
                1: begin
                    rel++;
                    if (rel == 8 * D) begin
                        if (rx) phase = 0;
                    end else if (rel > 8 * D && (rel - 8 * D) % BIT == 0) begin
                        k = (rel - 8 * D) / BIT;
                        if (k <= 8) begin
                            m_byte[3'(k - 1)] = rx;
                        end else if (rx) begin
                            comp = 1'b1; phase = 0;
                        end else begin
                            m_fe = 1'b1; phase = 2;
                        end
                    end
                end
                default: if (rx) phase = 0;
            endcase
            if (comp) begin
                m_ovr = rdAck ? 1'b0 : (m_da ? 1'b1 : m_ovr);
                m_da = 1'b1;
                m_data = m_byte;
            end else if (rdAck && m_da) begin
                m_da = 1'b0; m_ovr = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        cyc++;
        chk("rxData", rxData, m_data);
        chk("dataAvailable", {7'd0, dataAvailable}, {7'd0, m_da});
        chk("framingError", {7'd0, framingError}, {7'd0, m_fe});
        chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
        chk("busy", {7'd0, busy}, {7'd0, phase != 0});
        if (framingError) fe_count++;
        if (dataAvailable && !prev_da) rise_cyc = cyc;
        prev_da = dataAvailable;
    endtask

    task automatic idle(input int n);
        uartRxPin = 1'b1; rdAck = 1'b0; resetGral = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic ack_pulse();
        rdAck = 1'b1;
        cycle();
        rdAck = 1'b0;
        cycle();
    endtask

    // ack_at / rst_at: edge index after the falling edge at which to pulse that input (0 = never)
    task automatic send(input logic [7:0] b, input bit stop, input int ack_at, input int rst_at);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        fall_cyc = cyc;
        rise_cyc = -1;
        for (int j = 1; j <= 10 * BIT; j++) begin
            uartRxPin = frame[(j - 1) / BIT];
            rdAck = (j == ack_at);
            resetGral = (j == rst_at);
            cycle();
        end
        idle(4);
    endtask

    initial begin
        int fe0;
        logic [7:0] b;
        uartRxPin = 1'b1; rdAck = 1'b0; resetGral = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("reset_rxData", rxData, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        idle(10);

        send(8'hA5, 1'b1, 0, 0);
        chk("t1_data", rxData, 8'hA5);
        chk("t1_da", {7'd0, dataAvailable}, 8'h01);
        chk("t1_latency", 8'(rise_cyc - fall_cyc), 8'(3 + 152 * D));
        rdAck = 1'b1;
        cycle();
        rdAck = 1'b0;
        chk("t1_ack_clears", {7'd0, dataAvailable}, 8'h00);
        idle(8);

        fe0 = fe_count;
        uartRxPin = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        idle(200);
        chk("t2_busy", {7'd0, busy}, 8'h00);
        chk("t2_no_da", {7'd0, dataAvailable}, 8'h00);
        chk("t2_no_fe", 8'(fe_count - fe0), 8'h00);

        fe0 = fe_count;
        send(8'h3C, 1'b0, 0, 0);
        idle(20);
        chk("t3_one_fe", 8'(fe_count - fe0), 8'h01);
        chk("t3_da", {7'd0, dataAvailable}, 8'h00);
        chk("t3_data_kept", rxData, 8'hA5);
        send(8'h55, 1'b1, 0, 0);
        chk("t3_next", rxData, 8'h55);
        ack_pulse();

        send(8'h11, 1'b1, 0, 0);
        send(8'h22, 1'b1, 0, 0);
        chk("t4_data", rxData, 8'h22);
        chk("t4_ovr", {7'd0, overrun}, 8'h01);
        ack_pulse();
        chk("t4_ovr_clr", {7'd0, overrun}, 8'h00);
        chk("t4_da_clr", {7'd0, dataAvailable}, 8'h00);

        send(8'h11, 1'b1, 0, 0);
        send(8'h22, 1'b1, 3 + 152 * D, 0);
        chk("t5_da", {7'd0, dataAvailable}, 8'h01);
        chk("t5_ovr", {7'd0, overrun}, 8'h00);
        chk("t5_data", rxData, 8'h22);
        ack_pulse();

        send(8'hFF, 1'b1, 0, 5 * BIT + 32);
        chk("t6_data", rxData, 8'h00);
        chk("t6_da", {7'd0, dataAvailable}, 8'h00);
        chk("t6_busy", {7'd0, busy}, 8'h00);
        send(8'h81, 1'b1, 0, 0);
        chk("t6_next", rxData, 8'h81);
        ack_pulse();

        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            case ($urandom_range(0, 3))
                0: send(b, 1'b1, 3 + 152 * D, 0);
                1: send(b, 1'b1, $urandom_range(1, 10 * BIT), 0);
                2: send(b, ($urandom_range(0, 4) != 0), 0, 0);
                default: send(b, 1'b1, 0, 0);
            endcase
            idle($urandom_range(2, 40));
            if ($urandom_range(0, 1) == 1) ack_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
